// File: rtl/video_pkg.sv
// Shared video types: tile geometry, fetch FSM states,
// VRAM address type and fetch target bundle.
package video_pkg;

  localparam int TILE_W   = 8;
  localparam int MAP_COLS = 32;
  localparam int COL_W    = $clog2(MAP_COLS);

  typedef enum logic [2:0] {
    IDLE,
    VADDR,
    VWAIT,
    CADDR,
    CWAIT,
    LOAD
  } fetch_state_t;

  typedef logic [10:0] vram_addr_t;
  typedef logic [COL_W-1:0] col_t;

  typedef struct packed {
    col_t       row;
    col_t       col;
    logic [2:0] fine;
    logic       flip;
  } fetch_tgt_t;

  function automatic logic [7:0] bit_rev8(
    input logic [7:0] d
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_shifter.sv
// 8-bit parallel-load, MSB-first shift register.
// Ports: clk, reset_n, ce, load, din[7:0] -> msb.
import video_pkg::*;

module tile_shifter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] din,
  output logic       msb
);

  logic [7:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (ce) begin
      if (load) begin
        sr <= din;
      end else begin
        sr <= {sr[6:0], 1'b0};
      end
    end
  end

  assign msb = sr[7];

endmodule

// File: rtl/tile_fetch.sv
// Background tile fetch: VRAM code -> char ROM pattern
// -> 1-bit pixel stream. Ports: beam in, VRAM/ROM, pix out.
import video_pkg::*;

module tile_fetch #(
  parameter int HBLANK_START = 256,
  parameter int VBLANK_START = 224
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        flip,
  output logic [10:0] vram_addr,
  input  logic [7:0]  vram_q,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic        pix,
  output logic [7:0]  pix_code,
  output logic        pix_valid,
  output logic        fetch_late
);

  fetch_state_t state;
  fetch_state_t state_nx;
  fetch_tgt_t   tgt;
  fetch_tgt_t   tgt_nx;

  logic       tile_start;
  logic       tile_end;
  logic       pend_ready;
  logic [7:0] pend_pat;
  logic [7:0] pend_code;
  logic [7:0] load_pat;
  col_t       col_n;

  assign tile_start = ce_pix
    && (hcount[2:0] == 3'd0);
  assign tile_end = ce_pix
    && (hcount[2:0] == 3'(TILE_W-1));

  // Fetch one tile ahead of the beam.
  assign col_n = hcount[7:3] + col_t'(1);

  always_comb begin
    tgt_nx      = '0;
    tgt_nx.col  = col_n ^ {COL_W{flip}};
    tgt_nx.row  = vcount[7:3] ^ {COL_W{flip}};
    tgt_nx.fine = vcount[2:0] ^ {3{flip}};
    tgt_nx.flip = flip;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (tile_start) state_nx = VADDR;
      VADDR: state_nx = VWAIT;
      VWAIT: state_nx = CADDR;
      CADDR: state_nx = CWAIT;
      CWAIT: state_nx = LOAD;
      LOAD:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Target is latched at start so the fetch is
  // immune to the beam moving on underneath it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt        <= '0;
      vram_addr  <= '0;
      rom_addr   <= '0;
      pend_code  <= '0;
      pend_pat   <= '0;
      pend_ready <= 1'b0;
      pix_code   <= '0;
      pix_valid  <= 1'b0;
      fetch_late <= 1'b0;
    end else begin
      if (state == IDLE && tile_start) begin
        tgt <= tgt_nx;
      end
      if (state == VADDR) begin
        vram_addr <= vram_addr_t'(
          {1'b0, tgt.row, tgt.col});
      end
      if (state == CADDR) begin
        pend_code <= vram_q;
        rom_addr  <= {vram_q, tgt.fine};
      end
      if (tile_end) begin
        pend_ready <= 1'b0;
        pix_code   <= pend_code;
        if (!pend_ready) begin
          fetch_late <= 1'b1;
        end
      end
      // A completing fetch outranks the consume.
      if (state == LOAD) begin
        pend_pat   <= tgt.flip ? bit_rev8(rom_q)
                               : rom_q;
        pend_ready <= 1'b1;
      end
      if (ce_pix) begin
        pix_valid <= (hcount < 9'(HBLANK_START))
          && (vcount < 9'(VBLANK_START));
      end
    end
  end

  // A late tile shows blank rather than stale data.
  assign load_pat = pend_ready ? pend_pat : 8'h00;

  tile_shifter u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_pix),
    .load    (tile_end),
    .din     (load_pat),
    .msb     (pix)
  );

endmodule

// File: tb/tb_tile_fetch.sv
// Bench for tile_fetch: memory models, reference model,
// per-cycle compare plus directed literal checks.
module tb_tile_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pix = 1'b0;
  logic [8:0]  hcount = '0;
  logic [8:0]  vcount = '0;
  logic        flip = 1'b0;
  logic [10:0] vram_addr;
  logic [7:0]  vram_q = '0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q = '0;
  logic        pix;
  logic [7:0]  pix_code;
  logic        pix_valid;
  logic        fetch_late;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [7:0] vram [2048];
  logic [7:0] rom  [2048];

  tile_fetch #(
    .HBLANK_START (256),
    .VBLANK_START (224)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .hcount     (hcount),
    .vcount     (vcount),
    .flip       (flip),
    .vram_addr  (vram_addr),
    .vram_q     (vram_q),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix        (pix),
    .pix_code   (pix_code),
    .pix_valid  (pix_valid),
    .fetch_late (fetch_late)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_q <= vram[vram_addr];
    rom_q  <= rom[rom_addr];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch in flight as a cycle count,
  // current tile as a pattern plus pixel index.
  int         m_cnt;
  logic [10:0] m_addr;
  logic [2:0] m_fine;
  logic [7:0] m_code;
  logic [7:0] m_pat;
  logic [7:0] m_pend_code;
  logic [7:0] m_pend_pat;
  bit         m_ready;
  logic [7:0] m_cur;
  int         m_idx;
  logic [7:0] m_pix_code;
  bit         m_valid;
  bit         m_late;
  logic [10:0] m_vaddr;
  logic [10:0] m_raddr;

  task automatic model_reset();
    m_cnt = -1;
    m_addr = '0; m_fine = '0;
    m_code = '0; m_pat = '0;
    m_pend_code = '0; m_pend_pat = '0;
    m_ready = 0; m_cur = '0; m_idx = 8;
    m_pix_code = '0; m_valid = 0; m_late = 0;
    m_vaddr = '0; m_raddr = '0;
  endtask

  task automatic model_step();
    int col, row, fine;
    logic [7:0] p;
    if (ce_pix) begin
      if (hcount % 8 == 7) begin
        m_cur = m_ready ? m_pend_pat : 8'h00;
        m_idx = 0;
        m_pix_code = m_pend_code;
        if (!m_ready) m_late = 1;
        m_ready = 0;
      end else if (m_idx < 8) begin
        m_idx++;
      end
      m_valid = (hcount < 256) && (vcount < 224);
    end
    if (m_cnt < 0) begin
      if (ce_pix && hcount % 8 == 0) begin
        col = ((hcount % 256) / 8 + 1) % 32;
        row = (vcount % 256) / 8;
        fine = vcount % 8;
        if (flip) begin
          col = 31 - col;
          row = 31 - row;
          fine = 7 - fine;
        end
        m_addr = 11'(row * 32 + col);
        m_fine = 3'(fine);
        m_code = vram[m_addr];
        p = rom[m_code * 8 + fine];
        m_pat = p;
        if (flip)
          for (int i = 0; i < 8; i++)
            m_pat[i] = p[7-i];
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 1) m_vaddr = m_addr;
      if (m_cnt == 3) begin
        m_pend_code = m_code;
        m_raddr = {m_code, m_fine};
      end
      if (m_cnt == 5) begin
        m_pend_pat = m_pat;
        m_ready = 1;
        m_cnt = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("vram_addr", 32'(vram_addr), 32'(m_vaddr));
      chk("rom_addr", 32'(rom_addr), 32'(m_raddr));
      chk("pix", 32'(pix),
          32'(m_idx < 8 ? m_cur[7-m_idx] : 1'b0));
      chk("pix_code", 32'(pix_code), 32'(m_pix_code));
      chk("pix_valid", 32'(pix_valid), 32'(m_valid));
      chk("fetch_late", 32'(fetch_late), 32'(m_late));
    end
  end

  // Inputs change 3 time units after an edge.
  task automatic tick(input bit c, input int h,
                      input int v, input bit f);
    ce_pix = c;
    hcount = 9'(h);
    vcount = 9'(v);
    flip = f;
    @(posedge clk);
    #3;
  endtask

  task automatic do_ce(input int h, input int v,
                       input bit f);
    tick(1, h, v, f);
    tick(0, h, v, f);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, hcount, vcount, flip);
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  logic [7:0] exp_pat;

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'(i * 7 + 3);
      rom[i]  = 8'(i * 13 + 1);
    end
    vram[11'h021] = 8'h5A;
    rom[11'h2D2]  = 8'hA5;
    vram[11'h3DE] = 8'h33;
    rom[11'h19D]  = 8'h80;
    model_reset();

    @(posedge clk);
    #3;
    idle(2);
    chk("rst_vram_addr", 32'(vram_addr), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_fetch_late", 32'(fetch_late), 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    idle(3);

    // Normal fetch, ce every other clk.
    exp_pat = 8'hA5;
    do_ce(0, 10, 0);
    chk("norm_vram_addr", 32'(vram_addr), 32'h021);
    do_ce(1, 10, 0);
    chk("norm_rom_addr", 32'(rom_addr), 32'h2D2);
    for (int h = 2; h < 7; h++) begin
      do_ce(h, 10, 0);
      chk("norm_pre_pix", 32'(pix), 0);
    end
    for (int h = 7; h < 15; h++) begin
      do_ce(h, 10, 0);
      chk("norm_pix", 32'(pix), 32'(exp_pat[14-h]));
    end
    chk("norm_code", 32'(pix_code), 32'h5A);
    chk("norm_late", 32'(fetch_late), 0);
    do_ce(15, 10, 0);
    idle(8);

    // Reset while the fetch sits in CWAIT.
    tick(1, 0, 10, 0);
    idle(3);
    reset_n = 1'b0;
    #1;
    chk("mrst_vram_addr", 32'(vram_addr), 0);
    chk("mrst_rom_addr", 32'(rom_addr), 0);
    chk("mrst_pix_code", 32'(pix_code), 0);
    chk("mrst_pix_valid", 32'(pix_valid), 0);
    chk("mrst_pix", 32'(pix), 0);
    #2;
    idle(2);
    reset_n = 1'b1;
    idle(2);
    for (int h = 0; h < 7; h++) begin
      do_ce(h, 10, 0);
      chk("mrst_first_pix", 32'(pix), 0);
    end
    do_ce(7, 10, 0);
    chk("mrst_late", 32'(fetch_late), 0);
    idle(8);

    // Column wrap at the right edge.
    do_ce(248, 0, 0);
    chk("wrap_vram_addr", 32'(vram_addr), 0);
    for (int h = 249; h < 256; h++) do_ce(h, 0, 0);
    idle(8);

    // Flip: inverted address, fine row, bit order.
    exp_pat = 8'h01;
    do_ce(0, 10, 1);
    chk("flip_vram_addr", 32'(vram_addr), 32'h3DE);
    do_ce(1, 10, 1);
    chk("flip_rom_addr", 32'(rom_addr), 32'h19D);
    for (int h = 2; h < 7; h++) do_ce(h, 10, 1);
    for (int h = 7; h < 15; h++) begin
      do_ce(h, 10, 1);
      chk("flip_pix", 32'(pix), 32'(exp_pat[14-h]));
    end
    chk("flip_code", 32'(pix_code), 32'h33);
    do_ce(15, 10, 1);
    idle(8);

    // Blanking edges.
    do_ce(255, 223, 0);
    chk("blank_in", 32'(pix_valid), 1);
    do_ce(256, 10, 0);
    chk("blank_h", 32'(pix_valid), 0);
    do_ce(255, 223, 0);
    chk("blank_in2", 32'(pix_valid), 1);
    do_ce(0, 224, 0);
    chk("blank_v", 32'(pix_valid), 0);
    idle(8);

    // Late fetch: beam jumps so the tile ends early.
    hard_reset();
    tick(1, 0, 10, 0);
    for (int h = 4; h < 8; h++) tick(1, h, 10, 0);
    chk("late_flag", 32'(fetch_late), 1);
    chk("late_pix0", 32'(pix), 0);
    for (int h = 8; h < 15; h++) begin
      tick(1, h, 10, 0);
      chk("late_pix", 32'(pix), 0);
    end
    tick(1, 15, 10, 0);
    chk("late_next_pix", 32'(pix), 1);
    chk("late_next_code", 32'(pix_code), 32'h5A);
    for (int h = 16; h < 40; h++) tick(1, h, 10, 0);
    chk("late_sticky", 32'(fetch_late), 1);
    idle(4);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_fetch.md
Name: tile_fetch

Overview:
- Background character fetch stage that sits directly upstream of the dual-port video RAM's video-side port (port B) and the character ROM.
- Per 8-pixel tile, it issues the video RAM address, latches the returned tile code, issues the character ROM address and latches the pattern byte.
- It serialises the pattern MSB-first into a 1-bit pixel plus tile code, one tile ahead of the beam, for the colour/priority mixer.

Parameters:
- HBLANK_START, 256, first hcount value at which pix_valid deasserts.
- VBLANK_START, 224, first vcount value at which pix_valid deasserts.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel clock enable; at most one every clk, at least 6 clk between consecutive 8-pixel tile boundaries.
- hcount  in  9  current beam x, valid on ce_pix.
- vcount  in  9  current beam y, valid on ce_pix.
- flip  in  1  screen flip; inverts tile column/row and fine row.
- vram_addr  out  11  to video RAM port B address.
- vram_q  in  8  port B registered read data, valid 1 clk after vram_addr.
- rom_addr  out  11  {code[7:0], fine_row[2:0]} to character ROM.
- rom_q  in  8  ROM registered data, valid 1 clk after rom_addr.
- pix  out  1  current pattern bit.
- pix_code  out  8  tile code of current pixel's tile.
- pix_valid  out  1  high inside active area.
- fetch_late  out  1  sticky: a tile load occurred before its fetch completed.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, vram_addr=0, rom_addr=0, shift=0, pend_pat=0, pend_code=0, pix=0, pix_code=0, pix_valid=0, fetch_late=0, pend_ready=0. Reset mid-fetch aborts immediately; first post-reset tile outputs zero pattern.
- Fetch target:
  - col_next = hcount[7:3]+1, 5-bit wrap (col 31 -> 0).
  - row = vcount[7:3]; fine = vcount[2:0].
  - With flip=1: col/row bitwise inverted, fine inverted.
  - vram_addr = {1'b0, row, col_next} (lower 1 KB tilemap, bit 10 always 0).
- FSM (advances every clk, not gated by ce_pix):
  - IDLE: on ce_pix && hcount[2:0]==0 -> VADDR.
  - VADDR: drive vram_addr -> VWAIT.
  - VWAIT: 1-clk RAM latency -> CADDR.
  - CADDR: latch pend_code=vram_q; drive rom_addr={vram_q, fine} -> CWAIT.
  - CWAIT -> LOAD.
  - LOAD: pend_pat = rom_q (bit-reversed if flip); pend_ready=1 -> IDLE.
  - Total: 5 clk from start to pend_ready.
  - A new start condition while not IDLE is ignored.
- Serialiser (on ce_pix only):
  - hcount[2:0]==7: shift<=pend_pat, pix_code<=pend_code, pend_ready<=0; if pend_ready==0, fetch_late<=1 and shift<=0.
  - Otherwise: shift<=shift<<1.
  - pix = shift[7] (registered, no extra delay).
  - pix_valid registered on ce_pix: (hcount<HBLANK_START)&&(vcount<VBLANK_START).
- Latency: pixel on output during hcount=N+1 was fetched during tile of hcount=N-8..N-1 (one tile lead). Total ce_pix latency beam->pixel = 1.
- Outputs hold value when ce_pix=0.
- fetch_late clears only on reset.

Decomposition:
- Shared package (video_pkg): TILE_W=8, MAP_COLS=32, state enum {IDLE,VADDR,VWAIT,CADDR,CWAIT,LOAD}, 11-bit VRAM address type.
- One natural sub-module: tile_shifter (8-bit parallel-load/shift register with ce, load, flip-independent).
- FSM and address generation stay in the top.

Test Plan:
- Reset mid-fetch: assert reset_n=0 in CWAIT -> all outputs 0 asynchronously, state IDLE; after release, first tile pix stream all 0, fetch_late=0.
- Normal fetch: vram[0x021]=0x5A, rom[{0x5A,3'd2}]=0xA5, vcount=10, hcount 0..7 with ce every 2 clk -> vram_addr=0x021, rom_addr=0x2D2, hcount 8..15 pix = 1,0,1,0,0,1,0,1, pix_code=0x5A.
- Column wrap: hcount=248 start, vcount=0 -> vram_addr=0x000 (col 31+1 wraps to 0).
- Flip: flip=1, vcount=10, hcount=0 -> vram_addr={0,~5'd1,~5'd1}=0x3DE; fine=5; pattern 0xA5 bit-reversed = 0xA5 (palindrome); also 0x80 -> pix sequence 0,0,0,0,0,0,0,1.
- Late fetch: ce_pix every clk, force start 4 clk before hcount[2:0]==7 via hcount jump -> fetch_late=1, that tile pix all 0, later tiles normal.
- Blanking: hcount=256 or vcount=224 -> pix_valid=0 on next ce_pix; hcount=255, vcount=223 -> pix_valid=1.
